// File: rtl/jk_pkg.sv
// Shared JK mode encoding for the flip-flop cells and anything that drives them.
// The mode is the concatenation {j, k} for a single bit.
package jk_pkg;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TOG  = 2'b11;

    typedef enum logic [1:0] {
        MODE_HOLD = JK_HOLD,
        MODE_RST  = JK_RST,
        MODE_SET  = JK_SET,
        MODE_TOG  = JK_TOG
    } jk_mode_t;

endpackage

// File: rtl/jk_flip_flop_if.sv
// J/K control and Q/Q_n state bundle for a WIDTH-bit JK register.
// master drives j/k, slave (the flip-flop) drives q/q_n.
interface jk_flip_flop_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_n;

    modport master (output j, output k, input q, input q_n);
    modport slave  (input j, input k, output q, output q_n);
endinterface

// File: rtl/jk_flip_flop_bit.sv
// Single JK storage cell with synchronous active-low reset.
// Reset wins over any j/k combination, including unknowns.
module jk_bit
    import jk_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_j,
    input  logic i_k,
    output logic o_q
);
    logic r_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_q <= 1'b0;
        end else begin
            case (jk_mode_t'({i_j, i_k}))
                MODE_HOLD: r_q <= r_q;
                MODE_RST:  r_q <= 1'b0;
                MODE_SET:  r_q <= 1'b1;
                MODE_TOG:  r_q <= ~r_q;
                default:   r_q <= r_q;
            endcase
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/jk_flip_flop.sv
// WIDTH independent JK flip-flops; q_n is derived from q, never stored separately.
module jk_flip_flop
    import jk_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic            clk,
    input  logic            rst,
    jk_flip_flop_if.slave   bus
);
    logic [WIDTH-1:0] w_q;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        jk_bit u_bit (
            .i_clk (clk),
            .i_rst (rst),
            .i_j   (bus.j[g]),
            .i_k   (bus.k[g]),
            .o_q   (w_q[g])
        );
    end

    assign bus.q   = w_q;
    assign bus.q_n = ~w_q;
endmodule

// File: tb/tb_jk_flip_flop.sv
// Bench for jk_flip_flop: a 1-bit and a 4-bit instance checked against a mode-table model
// every cycle, plus literal expectations for the directed scenarios.
module tb_jk_flip_flop;
    import jk_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    jk_flip_flop_if #(.WIDTH(1)) bus1 ();
    jk_flip_flop_if #(.WIDTH(4)) bus4 ();

    jk_flip_flop #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    jk_flip_flop #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference state, derived from the mode table one bit at a time.
    logic [0:0] m_q1;
    logic [3:0] m_q4;
    bit         m_valid;

    function automatic logic next_q(input logic cur, input logic jj, input logic kk);
        jk_mode_t mode;
        mode = jk_mode_t'({jj, kk});
        if (mode == MODE_SET)      return 1'b1;
        else if (mode == MODE_RST) return 1'b0;
        else if (mode == MODE_TOG) return !cur;
        else                       return cur;
    endfunction

    initial begin
        m_valid = 1'b0;
        m_q1    = '0;
        m_q4    = '0;
    end

    always @(posedge clk) begin
        if (rst === 1'b0) begin
            m_q1    = '0;
            m_q4    = '0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_q1[0] = next_q(m_q1[0], bus1.j[0], bus1.k[0]);
            for (int b = 0; b < 4; b++)
                m_q4[b] = next_q(m_q4[b], bus4.j[b], bus4.k[b]);
        end
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    // Continuous compare at the falling edge, away from input changes and the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("cmp_q1",   {3'b0, bus1.q},   {3'b0, m_q1});
            check("cmp_qn1",  {3'b0, bus1.q_n}, {3'b0, ~m_q1});
            check("cmp_q4",   bus4.q,           m_q4);
            check("cmp_qn4",  bus4.q_n,         ~m_q4);
        end
    end

    // Apply inputs, take one rising edge, return 2 time units after it.
    task automatic step(input logic r, input logic j1, input logic k1,
                        input logic [3:0] j4, input logic [3:0] k4);
        rst    = r;
        bus1.j = j1;
        bus1.k = k1;
        bus4.j = j4;
        bus4.k = k4;
        @(posedge clk);
        #2;
    endtask

    task automatic step1(input logic r, input logic j1, input logic k1);
        step(r, j1, k1, 4'($urandom), 4'($urandom));
    endtask

    logic [7:0] sweep_j;
    logic [7:0] sweep_k;
    logic [7:0] sweep_q;

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        bus1.j  = '0;
        bus1.k  = '0;
        bus4.j  = '0;
        bus4.k  = '0;
        #1;

        // Reset with toggle requested: no toggling, q=0, q_n=1.
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 1'b1, 4'hF, 4'hF);
            check("rst_q1",  {3'b0, bus1.q},   4'b0000);
            check("rst_qn1", {3'b0, bus1.q_n}, 4'b0001);
            check("rst_q4",  bus4.q,           4'b0000);
            check("rst_qn4", bus4.q_n,         4'b1111);
        end

        // Mode sweep: 00,01,10,11,10,01,00,11 -> 0,0,1,0,1,0,0,1
        sweep_j = 8'b0011_1001;
        sweep_k = 8'b0101_0101;
        sweep_q = 8'b0010_1001;
        for (int i = 7; i >= 0; i--) begin
            step1(1'b1, sweep_j[i], sweep_k[i]);
            check("sweep_q",  {3'b0, bus1.q},   {3'b0, sweep_q[i]});
            check("sweep_qn", {3'b0, bus1.q_n}, {3'b0, ~sweep_q[i]});
        end

        // Toggle run from 0.
        step1(1'b1, 1'b0, 1'b1);
        check("tog_pre", {3'b0, bus1.q}, 4'b0000);
        for (int i = 0; i < 6; i++) begin
            step1(1'b1, 1'b1, 1'b1);
            check("tog_run", {3'b0, bus1.q}, (i % 2 == 0) ? 4'b0001 : 4'b0000);
        end

        // Reset mid-operation while set is requested, then release.
        step1(1'b1, 1'b1, 1'b0);
        check("mid_set", {3'b0, bus1.q}, 4'b0001);
        step1(1'b0, 1'b1, 1'b0);
        check("mid_rst", {3'b0, bus1.q}, 4'b0000);
        step1(1'b1, 1'b1, 1'b0);
        check("mid_rel", {3'b0, bus1.q}, 4'b0001);

        // Hold with j/k wiggling between edges; restored to 00 before each edge.
        for (int i = 0; i < 5; i++) begin
            rst    = 1'b1;
            bus1.j = 1'b0;
            bus1.k = 1'b0;
            #1;
            bus1.j = 1'b1;
            bus1.k = 1'b1;
            #2;
            check("hold_mid_a", {3'b0, bus1.q}, 4'b0001);
            bus1.j = 1'b1;
            bus1.k = 1'b0;
            #2;
            bus1.j = 1'b0;
            bus1.k = 1'b1;
            #1;
            check("hold_mid_b", {3'b0, bus1.q}, 4'b0001);
            bus1.j = 1'b0;
            bus1.k = 1'b0;
            @(posedge clk);
            #2;
            check("hold_edge", {3'b0, bus1.q}, 4'b0001);
        end

        // Vector independence on the 4-bit instance.
        step(1'b0, 1'b0, 1'b0, 4'hF, 4'hF);
        check("vec_rst", bus4.q, 4'b0000);
        step(1'b1, 1'b0, 1'b0, 4'b1010, 4'b0110);
        check("vec_e1", bus4.q, 4'b1010);
        check("vec_e1n", bus4.q_n, 4'b0101);
        step(1'b1, 1'b0, 1'b0, 4'b1010, 4'b0110);
        check("vec_e2", bus4.q, 4'b1000);

        // Randomized operation with occasional resets; the negedge compare does the checking.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 9) != 0), 1'($urandom), 1'($urandom),
                 4'($urandom), 4'($urandom));
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
